// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_sub_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    DONE = ENC_DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

  // Both channels are valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid must not depend on ready, and once done_valid
  // is raised diff and the flags hold until the transfer completes.
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master(
      output start_valid, a, b, done_ready,
      input start_ready, done_valid, diff, borrow_out, overflow, zero
  );

  modport slave(
      input start_valid, a, b, done_ready,
      output start_ready, done_valid, diff, borrow_out, overflow, zero
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational subtractor slice: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per
// clock, with borrow, signed-overflow and zero flags on a result handshake.
module serial_subtractor
  import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus,
    output state_t              state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sb_q, res_q, diff_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q, a_sign_q, b_sign_q;
    logic               borrow_out_q, overflow_q, zero_q;
    logic               bit_d, bit_bout;
    logic               accept, last_bit;
    logic [WIDTH-1:0]   res_shift;

    full_subtractor u_slice (
        .x   (sa_q[0]),
        .y   (sb_q[0]),
        .bin (borrow_q),
        .d   (bit_d),
        .bout(bit_bout)
    );

    assign accept    = bus.start_valid && (state_q == IDLE);
    assign last_bit  = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB so the LSB-first stream lands in place.
    assign res_shift = (res_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_valid) state_d = RUN;
            RUN:     if (last_bit)        state_d = DONE;
            DONE:    if (bus.done_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.start_ready = (state_q == IDLE);
        bus.done_valid  = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q         <= '0;
            sb_q         <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            a_sign_q     <= 1'b0;
            b_sign_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
        end else if (accept) begin
            sa_q     <= bus.a;
            sb_q     <= bus.b;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_sign_q <= bus.a[WIDTH-1];
            b_sign_q <= bus.b[WIDTH-1];
        end else if (state_q == RUN) begin
            sa_q     <= sa_q >> 1;
            sb_q     <= sb_q >> 1;
            res_q    <= res_shift;
            cnt_q    <= cnt_q + CNT_W'(1);
            borrow_q <= bit_bout;
            // Published outputs only change here, so they hold through IDLE/RUN.
            if (last_bit) begin
                diff_q       <= res_shift;
                borrow_out_q <= bit_bout;
                zero_q       <= (res_shift == '0);
                overflow_q   <= (a_sign_q != b_sign_q) && (bit_d != a_sign_q);
            end
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
    assign bus.zero       = zero_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (WIDTH=8) against an
// arithmetic reference model.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W = 8;

    logic   clk;
    logic   rst_n;
    state_t state_o;
    int     total = 0;
    int     bad = 0;

    logic [W+2:0] exp_q[$];
    logic [W+2:0] last_exp;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .state_o(state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {diff, borrow, overflow, zero} from plain integer arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, sr;
        logic [W-1:0] d;
        logic bo, ov;
        d  = x - y;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sr = sx - sy;
        bo = (int'(x) < int'(y));
        ov = (sr > 127) || (sr < -128);
        return {d, bo, ov, (d == '0)};
    endfunction

    function automatic logic [W+2:0] outs();
        return {bus.diff, bus.borrow_out, bus.overflow, bus.zero};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; with chain=1 start_valid stays high with (nxa,nxb)
    // through the DONE hold and release so the next call is accepted one cycle later.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input int hold,
                          input bit chain, input logic [W-1:0] nxa, input logic [W-1:0] nxb);
        logic [W+2:0] exp;
        int cycles;
        @(negedge clk);
        check("idle_ready", 32'(bus.start_ready), 32'd1);
        bus.start_valid = 1'b1;
        bus.a = ai;
        bus.b = bi;
        exp_q.push_back(model(ai, bi));
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        check("accepted_run", 32'(state_o), 32'(RUN));
        check("run_outputs_held", 32'(outs()), 32'(last_exp));
        cycles = 0;
        while (bus.done_valid !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency", 32'(cycles), 32'(W));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("result", 32'(outs()), 32'(exp));
        last_exp = exp;
        for (int i = 0; i < hold; i++) begin
            bus.start_valid = 1'b1;
            bus.a = chain ? nxa : W'($urandom);
            bus.b = chain ? nxb : W'($urandom);
            @(posedge clk);
            #1;
            check("hold_result", 32'(outs()), 32'(exp));
            check("hold_no_accept", 32'({bus.start_ready, bus.done_valid}), 32'(2'b01));
        end
        bus.start_valid = chain;
        bus.a = nxa;
        bus.b = nxb;
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
        check("release_idle", 32'(state_o), 32'(IDLE));
        check("release_hs", 32'({bus.start_ready, bus.done_valid}), 32'(2'b10));
        check("idle_outputs_held", 32'(outs()), 32'(exp));
    endtask

    initial begin
        logic [W-1:0] corner[8];
        logic [W-1:0] ra, rb;
        corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F; corner[3] = 8'h80;
        corner[4] = 8'hFF; corner[5] = 8'hFE; corner[6] = 8'h81; corner[7] = 8'h40;

        rst_n = 1'b0;
        bus.start_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.done_ready = 1'b0;
        last_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(state_o), 32'(IDLE));
        check("reset_hs", 32'({bus.start_ready, bus.done_valid}), 32'(2'b10));
        check("reset_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed examples
        run_op(8'h05, 8'h03, 0, 1'b0, '0, '0);
        run_op(8'h03, 8'h05, 1, 1'b0, '0, '0);
        run_op(8'h80, 8'h01, 0, 1'b0, '0, '0);
        run_op(8'h55, 8'h55, 5, 1'b1, 8'h7F, 8'hFF);
        run_op(8'h7F, 8'hFF, 0, 1'b0, '0, '0);
        run_op(8'h00, 8'hFF, 2, 1'b0, '0, '0);

        // asynchronous reset in RUN with count at 3
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.a = 8'hC3;
        bus.b = 8'h1A;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_run", 32'(state_o), 32'(RUN));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state_o), 32'(IDLE));
        check("async_reset_hs", 32'({bus.start_ready, bus.done_valid}), 32'(2'b10));
        check("async_reset_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
        exp_q.delete();
        run_op(8'h80, 8'h7F, 0, 1'b0, '0, '0);

        // randomized operands, corner values mixed in
        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : W'($urandom);
            run_op(ra, rb, $urandom_range(0, 3), 1'b0, '0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
